// File: rtl/ps2_mouse_packet_decoder.sv
// PS/2 mouse packet decoder: frames the PS2_Controller byte stream into 3-byte
// mouse packets, reports buttons and signed deltas, and tracks a clamped cursor.
module ps2_mouse_packet_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 100_000,
    parameter int unsigned X_MAX          = 159,
    parameter int unsigned Y_MAX          = 119,
    parameter int unsigned X_INIT         = 80,
    parameter int unsigned Y_INIT         = 60
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] rx_data,
    input  logic       rx_data_en,
    output logic       packet_valid,
    output logic [2:0] buttons,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic [7:0] cursor_x,
    output logic [6:0] cursor_y,
    output logic       sync_error
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] BYTE_ACK      = 8'hFA;
    localparam logic [7:0] BYTE_SELFTEST = 8'hAA;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2
    } state_t;

    state_t              r_state;
    logic [7:0]          r_b0;
    logic [7:0]          r_b1;
    logic [CNT_W-1:0]    r_cnt;

    logic [8:0]          w_dx;
    logic [8:0]          w_dy;
    logic signed [10:0]  w_sum_x;
    logic signed [10:0]  w_sum_y;
    logic [7:0]          w_next_x;
    logic [6:0]          w_next_y;
    logic                w_timeout;

    // Packet decode (b2 taken straight from the bus) and clamped cursor update
    always_comb begin
        w_dx = {r_b0[4], r_b1};
        if (r_b0[6]) begin
            w_dx = r_b0[4] ? 9'h100 : 9'h0FF;
        end
        w_dy = {r_b0[5], rx_data};
        if (r_b0[7]) begin
            w_dy = r_b0[5] ? 9'h100 : 9'h0FF;
        end

        w_sum_x = $signed({3'b000, cursor_x}) + $signed({{2{w_dx[8]}}, w_dx});
        w_sum_y = $signed({4'b0000, cursor_y}) - $signed({{2{w_dy[8]}}, w_dy});

        if (w_sum_x[10]) begin
            w_next_x = 8'd0;
        end else if (w_sum_x > $signed(11'(X_MAX))) begin
            w_next_x = 8'(X_MAX);
        end else begin
            w_next_x = w_sum_x[7:0];
        end

        if (w_sum_y[10]) begin
            w_next_y = 7'd0;
        end else if (w_sum_y > $signed(11'(Y_MAX))) begin
            w_next_y = 7'(Y_MAX);
        end else begin
            w_next_y = w_sum_y[6:0];
        end

        w_timeout = (r_cnt >= CNT_LAST);
    end

    // Framing FSM, inter-byte timeout and registered outputs
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state      <= WAIT_B0;
            r_b0         <= 8'd0;
            r_b1         <= 8'd0;
            r_cnt        <= '0;
            packet_valid <= 1'b0;
            sync_error   <= 1'b0;
            buttons      <= 3'd0;
            dx           <= 9'd0;
            dy           <= 9'd0;
            cursor_x     <= 8'(X_INIT);
            cursor_y     <= 7'(Y_INIT);
        end else begin
            packet_valid <= 1'b0;
            sync_error   <= 1'b0;

            if (rx_data_en || (r_state == WAIT_B0)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            case (r_state)
                WAIT_B0: begin
                    if (rx_data_en && (rx_data != BYTE_ACK) && (rx_data != BYTE_SELFTEST)) begin
                        if (rx_data[3]) begin
                            r_b0    <= rx_data;
                            r_state <= WAIT_B1;
                        end else begin
                            sync_error <= 1'b1;
                        end
                    end
                end
                WAIT_B1: begin
                    if (rx_data_en) begin
                        r_b1    <= rx_data;
                        r_state <= WAIT_B2;
                    end else if (w_timeout) begin
                        r_state    <= WAIT_B0;
                        sync_error <= 1'b1;
                    end
                end
                WAIT_B2: begin
                    if (rx_data_en) begin
                        r_state      <= WAIT_B0;
                        packet_valid <= 1'b1;
                        buttons      <= r_b0[2:0];
                        dx           <= w_dx;
                        dy           <= w_dy;
                        cursor_x     <= w_next_x;
                        cursor_y     <= w_next_y;
                    end else if (w_timeout) begin
                        r_state    <= WAIT_B0;
                        sync_error <= 1'b1;
                    end
                end
                default: begin
                    r_state <= WAIT_B0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Directed, table-driven bench for ps2_mouse_packet_decoder.
module tb_ps2_mouse_packet_decoder;

    localparam int unsigned T_OUT = 200;

    logic       clk;
    logic       resetn;
    logic [7:0] rx_data;
    logic       rx_data_en;
    logic       packet_valid;
    logic [2:0] buttons;
    logic [8:0] dx;
    logic [8:0] dy;
    logic [7:0] cursor_x;
    logic [6:0] cursor_y;
    logic       sync_error;

    int n_checks = 0;
    int n_errors = 0;

    ps2_mouse_packet_decoder #(
        .TIMEOUT_CYCLES(T_OUT),
        .X_MAX(159),
        .Y_MAX(119),
        .X_INIT(80),
        .Y_INIT(60)
    ) dut (
        .CLOCK_50    (clk),
        .resetn      (resetn),
        .rx_data     (rx_data),
        .rx_data_en  (rx_data_en),
        .packet_valid(packet_valid),
        .buttons     (buttons),
        .dx          (dx),
        .dy          (dy),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .sync_error  (sync_error)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         btn;
        int         edx;
        int         edy;
        int         ecx;
        int         ecy;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; strobes one byte and returns at the following negedge
    task automatic send_byte(input logic [7:0] b);
        rx_data    = b;
        rx_data_en = 1'b1;
        @(negedge clk);
        rx_data_en = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
    endtask

    task automatic chk_out(input string tag, input int btn, input int edx, input int edy,
                           input int ecx, input int ecy);
        chk({tag, ".buttons"}, int'(buttons), btn);
        chk({tag, ".dx"}, int'($signed(dx)), edx);
        chk({tag, ".dy"}, int'($signed(dy)), edy);
        chk({tag, ".cursor_x"}, int'(cursor_x), ecx);
        chk({tag, ".cursor_y"}, int'(cursor_y), ecy);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk("reset.packet_valid", int'(packet_valid), 0);
        chk("reset.sync_error", int'(sync_error), 0);
        chk_out("reset", 0, 0, 0, 80, 60);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int seen;
        int exp_x;

        vecs[0] = '{8'h08, 8'h05, 8'h03, 0,    5,    3,  85,  57};
        vecs[1] = '{8'h39, 8'hFB, 8'hFE, 1,   -5,   -2,  80,  59};
        vecs[2] = '{8'h0A, 8'h00, 8'h00, 2,    0,    0,  80,  59};
        vecs[3] = '{8'h0C, 8'h14, 8'h00, 4,   20,    0, 100,  59};
        vecs[4] = '{8'h88, 8'h00, 8'h12, 0,    0,  255, 100,   0};
        vecs[5] = '{8'hB8, 8'hF6, 8'h00, 0,  -10, -256,  90, 119};
        vecs[6] = '{8'h48, 8'h10, 8'h00, 0,  255,    0, 159, 119};
        vecs[7] = '{8'h58, 8'h33, 8'h05, 0, -256,    5,   0, 114};

        rx_data    = 8'h00;
        rx_data_en = 1'b0;
        resetn     = 1'b1;
        @(negedge clk);
        do_reset();

        // Table: packets applied in order, cursor accumulates
        for (int i = 0; i < 8; i++) begin
            send_byte(vecs[i].b0);
            chk("tbl.pv_b0", int'(packet_valid), 0);
            send_byte(vecs[i].b1);
            chk("tbl.pv_b1", int'(packet_valid), 0);
            send_byte(vecs[i].b2);
            chk("tbl.pv", int'(packet_valid), 1);
            chk("tbl.se", int'(sync_error), 0);
            chk_out($sformatf("tbl%0d", i), vecs[i].btn, vecs[i].edx, vecs[i].edy,
                    vecs[i].ecx, vecs[i].ecy);
            @(negedge clk);
            chk("tbl.pv_drop", int'(packet_valid), 0);
            chk_out($sformatf("tbl%0d_hold", i), vecs[i].btn, vecs[i].edx, vecs[i].edy,
                    vecs[i].ecx, vecs[i].ecy);
        end

        // Back-to-back: next packet's first byte lands during packet_valid
        send_pkt(8'h08, 8'h03, 8'h00);
        chk("b2b.pvA", int'(packet_valid), 1);
        chk_out("b2bA", 0, 3, 0, 3, 114);
        send_pkt(8'h09, 8'h02, 8'h01);
        chk("b2b.pvB", int'(packet_valid), 1);
        chk_out("b2bB", 1, 2, 1, 5, 113);
        @(negedge clk);

        // Framing error, then ack/self-test bytes ignored
        send_byte(8'h02);
        chk("t4.se", int'(sync_error), 1);
        chk("t4.pv", int'(packet_valid), 0);
        send_byte(8'hFA);
        chk("t4.se_fa", int'(sync_error), 0);
        send_byte(8'hAA);
        chk("t4.se_aa", int'(sync_error), 0);
        send_byte(8'h08);
        chk("t4.pv_b0", int'(packet_valid), 0);
        send_byte(8'h01);
        chk("t4.pv_b1", int'(packet_valid), 0);
        send_byte(8'h01);
        chk("t4.pv", int'(packet_valid), 1);
        chk_out("t4", 0, 1, 1, 6, 112);
        @(negedge clk);

        // Timeout mid-packet
        send_byte(8'h08);
        send_byte(8'h05);
        seen = 0;
        for (int c = 1; c <= 3 * T_OUT; c++) begin
            if (packet_valid) chk("t5.no_pv", int'(packet_valid), 0);
            if (sync_error) begin
                seen = c;
                break;
            end
            @(negedge clk);
        end
        chk("t5.timeout_seen", int'(seen != 0), 1);
        chk("t5.timeout_near", int'(seen >= T_OUT - 1 && seen <= T_OUT + 1), 1);
        @(negedge clk);
        chk("t5.se_drop", int'(sync_error), 0);
        send_pkt(8'h08, 8'h01, 8'h01);
        chk("t5.pv", int'(packet_valid), 1);
        chk_out("t5", 0, 1, 1, 7, 111);
        @(negedge clk);

        // Byte arriving on the timeout cycle wins
        send_byte(8'h08);
        send_byte(8'h05);
        repeat (T_OUT - 1) @(negedge clk);
        chk("race.se_before", int'(sync_error), 0);
        send_byte(8'h03);
        chk("race.se", int'(sync_error), 0);
        chk("race.pv", int'(packet_valid), 1);
        chk_out("race", 0, 5, 3, 12, 108);
        @(negedge clk);

        // Reset in the middle of a packet
        send_byte(8'h48);
        do_reset();
        send_byte(8'h10);
        chk("t6.se_10", int'(sync_error), 1);
        chk("t6.pv_10", int'(packet_valid), 0);
        send_byte(8'h00);
        chk("t6.se_00", int'(sync_error), 1);
        send_pkt(8'h48, 8'h10, 8'h00);
        chk("t6.pv", int'(packet_valid), 1);
        chk_out("t6", 0, 255, 0, 159, 60);
        @(negedge clk);

        // Left-clamp: repeated -1 steps from reset
        do_reset();
        exp_x = 80;
        for (int k = 0; k < 100; k++) begin
            send_pkt(8'h18, 8'hFF, 8'h00);
            exp_x = (exp_x > 0) ? exp_x - 1 : 0;
            chk("t3.cursor_x", int'(cursor_x), exp_x);
        end
        chk_out("t3", 0, -1, 0, 0, 60);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
